// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sharing of data memory port A among NREQ requesters with in-order read returns
module data_mem_arbiter #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic [ADDR_W-1:0]      address_a,
    output logic [DATA_W-1:0]      data_a,
    output logic                   wren_a,
    input  logic [DATA_W-1:0]      q_a
);
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]    ptr_q, ptr_d, win, cand;
    logic              found;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d, rdata_q, rdata_d;
    logic              wren_q, wren_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [IDW:0]      push;
    logic [IDW:0]      pipe_q [MEM_LAT+1];

    // Round-robin search: first valid requester after the last winner
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign req_ready = found ? (NREQ'(1) << win) : '0;

    // Next state: issue winner's op, idle cycles never write, retire the oldest read
    always_comb begin
        ptr_d       = found ? win : ptr_q;
        addr_d      = found ? req_addr[win*ADDR_W +: ADDR_W] : addr_q;
        data_d      = found ? req_wdata[win*DATA_W +: DATA_W] : data_q;
        wren_d      = found & req_we[win];
        push        = {found & ~req_we[win], win};
        rsp_valid_d = pipe_q[MEM_LAT][IDW] ? (NREQ'(1) << pipe_q[MEM_LAT][IDW-1:0]) : '0;
        rdata_d     = pipe_q[MEM_LAT][IDW] ? q_a : rdata_q;
    end

    // Pointer, memory port A registers and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            wren_q      <= 1'b0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wren_q      <= wren_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    // Return-tracking shift pipe: one {is_read, id} entry per cycle, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= MEM_LAT; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= push;
            for (int k = 1; k <= MEM_LAT; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign address_a = addr_q;
    assign data_a    = data_q;
    assign wren_a    = wren_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed checks of the arbiter at MEM_LAT=1 and MEM_LAT=2 side by side
module tb_data_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid, req_we;
    logic [19:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  rdy1, rdy2, rv1, rv2;
    logic [7:0]  rd1, rd2, da1, da2, q1a, q2a, q2b;
    logic [9:0]  a1, a2;
    logic        we1, we2;
    logic [7:0]  mem1 [1024];
    logic [7:0]  mem2 [1024];
    int tests = 0, fails = 0, cyc = 0;

    typedef struct {int c; logic [1:0] v; logic [7:0] d;} rsp_t;
    rsp_t log1[$], log2[$];

    data_mem_arbiter #(.NREQ(2), .ADDR_W(10), .DATA_W(8), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1),
        .address_a(a1), .data_a(da1), .wren_a(we1), .q_a(q1a));

    data_mem_arbiter #(.NREQ(2), .ADDR_W(10), .DATA_W(8), .MEM_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv2), .rsp_rdata(rd2),
        .address_a(a2), .data_a(da2), .wren_a(we2), .q_a(q2b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: contents = low address byte while in reset, latency 1 and 2
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) begin
                mem1[i] <= 8'(i);
                mem2[i] <= 8'(i);
            end
        end else begin
            if (we1) mem1[a1] <= da1;
            if (we2) mem2[a2] <= da2;
        end
        q1a <= mem1[a1];
        q2a <= mem2[a2];
        q2b <= q2a;
    end

    // Response monitor
    always @(negedge clk) begin
        if (rv1 != 2'b00) log1.push_back('{cyc, rv1, rd1});
        if (rv2 != 2'b00) log2.push_back('{cyc, rv2, rd2});
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (a1 !== 10'h0 || da1 !== 8'h0 || we1 !== 1'b0 || rv1 !== 2'b00 || rd1 !== 8'h0 ||
            a2 !== 10'h0 || da2 !== 8'h0 || we2 !== 1'b0 || rv2 !== 2'b00 || rd2 !== 8'h0) begin
            fails++;
            $display("FAIL reset_state: a=%h/%h d=%h/%h we=%b/%b rv=%b/%b rd=%h/%h want all zero",
                     a1, a2, da1, da2, we1, we2, rv1, rv2, rd1, rd2);
        end
        rst_n = 1'b1;
        req_valid = 2'b01; req_we = 2'b00; req_addr = {10'h000, 10'h010};
        @(posedge clk); #1;
        req_valid = 2'b00;
        tests++;
        if (a1 !== 10'h010 || a2 !== 10'h010) begin
            fails++;
            $display("FAIL reset_accept: address_a=%h/%h want 010", a1, a2);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (we1 !== 1'b0 || we2 !== 1'b0 || a1 !== 10'h0 || a2 !== 10'h0) begin
            fails++;
            $display("FAIL reset_async: wren=%b/%b addr=%h/%h want 0/0 000/000", we1, we2, a1, a2);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (log1.size() != 0 || log2.size() != 0 || we1 !== 1'b0 || we2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_drop: responses=%0d/%0d wren=%b/%b want 0/0 0/0",
                     log1.size(), log2.size(), we1, we2);
        end
    endtask

    task automatic test_single();
        int e0;
        log1.delete(); log2.delete();
        req_valid = 2'b01; req_we = 2'b01; req_addr = {10'h000, 10'h003}; req_wdata = {8'h00, 8'hA5};
        #1;
        tests++;
        if (rdy1 !== 2'b01 || rdy2 !== 2'b01) begin
            fails++;
            $display("FAIL single_wr_ready: got %b/%b want 01", rdy1, rdy2);
        end
        @(posedge clk); #1;
        tests++;
        if (we1 !== 1'b1 || a1 !== 10'h003 || da1 !== 8'hA5 || we2 !== 1'b1 || a2 !== 10'h003 || da2 !== 8'hA5) begin
            fails++;
            $display("FAIL single_wr_issue: we=%b/%b a=%h/%h d=%h/%h want 1 003 a5", we1, we2, a1, a2, da1, da2);
        end
        req_we = 2'b00;
        #1;
        tests++;
        if (rdy1 !== 2'b01 || rdy2 !== 2'b01) begin
            fails++;
            $display("FAIL single_rd_ready: got %b/%b want 01", rdy1, rdy2);
        end
        e0 = cyc + 1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (log1.size() != 1 || log1[0].c != e0 + 2 || log1[0].v !== 2'b01 || log1[0].d !== 8'hA5) begin
            fails++;
            $display("FAIL single_rsp_lat1: n=%0d c=%0d v=%b d=%h want 1 %0d 01 a5", log1.size(),
                     log1.size() > 0 ? log1[0].c : -1, log1.size() > 0 ? log1[0].v : 2'bxx,
                     log1.size() > 0 ? log1[0].d : 8'hxx, e0 + 2);
        end
        tests++;
        if (log2.size() != 1 || log2[0].c != e0 + 3 || log2[0].v !== 2'b01 || log2[0].d !== 8'hA5) begin
            fails++;
            $display("FAIL single_rsp_lat2: n=%0d c=%0d v=%b d=%h want 1 %0d 01 a5", log2.size(),
                     log2.size() > 0 ? log2[0].c : -1, log2.size() > 0 ? log2[0].v : 2'bxx,
                     log2.size() > 0 ? log2[0].d : 8'hxx, e0 + 3);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] eg [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        logic [7:0] ed [6] = '{8'h30, 8'h20, 8'h31, 8'h21, 8'h32, 8'h22};
        int n0 = 0, n1 = 0, e0;
        log1.delete(); log2.delete();
        req_we = 2'b00; req_valid = 2'b11;
        e0 = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            req_addr = {10'(10'h030 + n1), 10'(10'h020 + n0)};
            #1;
            tests++;
            if (rdy1 !== eg[k] || rdy2 !== eg[k]) begin
                fails++;
                $display("FAIL rr_grant%0d: got %b/%b want %b", k, rdy1, rdy2, eg[k]);
            end
            @(posedge clk); #1;
            if (eg[k][1]) n1++; else n0++;
        end
        req_valid = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (log1.size() != 6 || log2.size() != 6) begin
            fails++;
            $display("FAIL rr_rsp_count: got %0d/%0d want 6/6", log1.size(), log2.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                tests++;
                if (log1[k].c != e0 + k + 2 || log1[k].v !== eg[k] || log1[k].d !== ed[k] ||
                    log2[k].c != e0 + k + 3 || log2[k].v !== eg[k] || log2[k].d !== ed[k]) begin
                    fails++;
                    $display("FAIL rr_rsp%0d: c=%0d/%0d v=%b/%b d=%h/%h want c=%0d/%0d v=%b d=%h", k,
                             log1[k].c, log2[k].c, log1[k].v, log2[k].v, log1[k].d, log2[k].d,
                             e0 + k + 2, e0 + k + 3, eg[k], ed[k]);
                end
            end
        end
    endtask

    task automatic test_fairness();
        logic [1:0] vin [4] = '{2'b11, 2'b11, 2'b10, 2'b10};
        logic [1:0] eg  [4] = '{2'b10, 2'b01, 2'b10, 2'b10};
        req_we = 2'b00; req_addr = {10'h040, 10'h050};
        for (int k = 0; k < 4; k++) begin
            req_valid = vin[k];
            #1;
            tests++;
            if (rdy1 !== eg[k] || rdy2 !== eg[k]) begin
                fails++;
                $display("FAIL fair_grant%0d: got %b/%b want %b", k, rdy1, rdy2, eg[k]);
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_idle_gap();
        req_valid = 2'b10; req_we = 2'b10; req_addr = {10'h100, 10'h000}; req_wdata = {8'h5C, 8'h00};
        #1;
        tests++;
        if (rdy1 !== 2'b10 || rdy2 !== 2'b10) begin
            fails++;
            $display("FAIL idle_ready1: got %b/%b want 10", rdy1, rdy2);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        tests++;
        if (we1 !== 1'b0 || a1 !== 10'h100 || da1 !== 8'h5C || we2 !== 1'b0 || a2 !== 10'h100 || da2 !== 8'h5C) begin
            fails++;
            $display("FAIL idle_hold: we=%b/%b a=%h/%h d=%h/%h want 0 100 5c", we1, we2, a1, a2, da1, da2);
        end
        req_valid = 2'b01; req_we = 2'b01; req_addr = {10'h000, 10'h101}; req_wdata = {8'h00, 8'h3E};
        #1;
        tests++;
        if (rdy1 !== 2'b01 || rdy2 !== 2'b01) begin
            fails++;
            $display("FAIL idle_ready2: got %b/%b want 01", rdy1, rdy2);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (mem1[10'h100] !== 8'h5C || mem1[10'h101] !== 8'h3E || mem1[10'h0FF] !== 8'hFF ||
            mem2[10'h100] !== 8'h5C || mem2[10'h101] !== 8'h3E || mem2[10'h0FF] !== 8'hFF) begin
            fails++;
            $display("FAIL idle_mem: [100]=%h/%h [101]=%h/%h [0ff]=%h/%h want 5c 3e ff",
                     mem1[10'h100], mem2[10'h100], mem1[10'h101], mem2[10'h101], mem1[10'h0FF], mem2[10'h0FF]);
        end
    endtask

    task automatic test_cross_raw();
        log1.delete(); log2.delete();
        req_valid = 2'b10; req_we = 2'b00; req_addr = {10'h101, 10'h000};
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (log1.size() != 1 || log2.size() != 1 || log1[0].v !== 2'b10 || log1[0].d !== 8'h3E ||
            log2[0].v !== 2'b10 || log2[0].d !== 8'h3E) begin
            fails++;
            $display("FAIL cross_raw: n=%0d/%0d v=%b/%b d=%h/%h want 1 10 3e", log1.size(), log2.size(),
                     log1.size() > 0 ? log1[0].v : 2'bxx, log2.size() > 0 ? log2[0].v : 2'bxx,
                     log1.size() > 0 ? log1[0].d : 8'hxx, log2.size() > 0 ? log2[0].d : 8'hxx);
        end
    endtask

    initial begin
        req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_idle_gap();
        test_cross_raw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
